sd_data_phy: RTL and testbench

Serial physical layer for the SD host DATA path, directly downstream of the DATA controller. It receives Send/Idle/WriteRead from the controller and words from the TX FIFO. It serializes blocks onto the single data line, or deserializes incoming blocks into the RX FIFO. It reports Serial_ready, Complete, Timeout and CRC_error back to the controller.

---
 rtl/sd_data_phy_pkg.sv | 10 +
 rtl/sd_data_phy_if.sv | 18 +
 rtl/sd_crc16_serial.sv | 15 +
 rtl/sd_data_phy.sv | 149 ++++++++++++++
 tb/tb_sd_data_phy.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sd_data_phy_pkg.sv
// sd_data_phy_pkg: shared state encoding and line/CRC constants for the SD DATA PHY
package sd_data_phy_pkg;
  typedef enum logic [3:0] {
    IDLE, WR_START, WR_DATA, WR_CRC, WR_END, RD_WAIT, RD_DATA, RD_CRC, RD_END, DONE
  } state_t;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT = 1'b1;
  localparam int CRC_LEN = 16;
endpackage

// File: rtl/sd_data_phy_if.sv
// sd_data_phy_if: controller/FIFO/pin bundle between the DATA controller and the serial PHY
interface sd_data_phy_if #(parameter int TO_WIDTH = 16);
  logic Send, Idle, WriteRead, Timeout_enable;
  logic [TO_WIDTH-1:0] Timeout_reg;
  logic [31:0] Data_from_FIFO, Data_to_FIFO;
  logic Data_pin_in, Data_pin_out, Data_pin_oe;
  logic Read_FIFO, Write_FIFO, Serial_ready, Complete, Timeout, CRC_error;
  modport master (
    output Send, Idle, WriteRead, Timeout_enable, Timeout_reg, Data_from_FIFO, Data_pin_in,
    input Data_pin_out, Data_pin_oe, Read_FIFO, Data_to_FIFO, Write_FIFO, Serial_ready,
    Complete, Timeout, CRC_error
  );
  modport slave (
    input Send, Idle, WriteRead, Timeout_enable, Timeout_reg, Data_from_FIFO, Data_pin_in,
    output Data_pin_out, Data_pin_oe, Read_FIFO, Data_to_FIFO, Write_FIFO, Serial_ready,
    Complete, Timeout, CRC_error
  );
endinterface

// File: rtl/sd_crc16_serial.sv
// sd_crc16_serial: bit-serial CRC16-CCITT (x^16+x^12+x^5+1), zero initial value
module sd_crc16_serial import sd_data_phy_pkg::*; (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  input logic din,
  output logic [15:0] crc
);
  logic fb;
  assign fb = din ^ crc[15];
  always_ff @(posedge clk)
    if (rst || clr) crc <= '0;
    else if (en) crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
endmodule

// File: rtl/sd_data_phy.sv
// sd_data_phy: SD DATA-line serializer/deserializer with start-bit timeout
// CRC16 generation/checking is built only when SD_DATA_CRC16_EN is defined.
module sd_data_phy import sd_data_phy_pkg::*; #(
  parameter int BLOCK_WORDS = 128,
  parameter int TO_WIDTH = 16
) (
  input logic SD_clock,
  input logic Reset,
  sd_data_phy_if.slave bus
);
  localparam int WW = BLOCK_WORDS > 1 ? $clog2(BLOCK_WORDS) : 1;
  state_t state;
  logic [31:0] sreg, tx_next;
  logic [4:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic last_word, data_last, tx_load, tx_bit;
  assign last_word = word_cnt == WW'(BLOCK_WORDS - 1);
  assign data_last = bit_cnt == 5'd31 && last_word;
  assign tx_load = state == WR_START || (state == WR_DATA && bit_cnt == 5'd31 && !last_word);
  assign tx_bit = tx_load ? bus.Data_from_FIFO[31] : sreg[31];
  assign tx_next = tx_load ? {bus.Data_from_FIFO[30:0], 1'b0} : {sreg[30:0], 1'b0};
`ifdef SD_DATA_CRC16_EN
  logic [15:0] crc;
  logic crc_en, crc_bit, crc_clr;
  // TX feeds each data bit as it is loaded onto the pin, so the CRC is final by the last data edge
  assign crc_en = state == WR_START || (state == WR_DATA && !data_last) || state == RD_DATA;
  assign crc_bit = state == RD_DATA ? bus.Data_pin_in : tx_bit;
  assign crc_clr = state == IDLE || bus.Idle;
  sd_crc16_serial u_crc (
    .clk(SD_clock), .rst(Reset), .clr(crc_clr), .en(crc_en), .din(crc_bit), .crc(crc)
  );
`endif
  always_ff @(posedge SD_clock) begin
    bus.Read_FIFO <= 1'b0;
    bus.Write_FIFO <= 1'b0;
    bus.Complete <= 1'b0;
    bus.Timeout <= 1'b0;
    bus.CRC_error <= 1'b0;
    if (Reset) begin
      state <= IDLE;
      bus.Serial_ready <= 1'b1;
      bus.Data_pin_out <= 1'b1;
      bus.Data_pin_oe <= 1'b0;
      bus.Data_to_FIFO <= '0;
      sreg <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      to_cnt <= '0;
    end else if (bus.Idle) begin
      state <= IDLE;
      bus.Serial_ready <= 1'b1;
      bus.Data_pin_out <= 1'b1;
      bus.Data_pin_oe <= 1'b0;
    end else case (state)
      IDLE: if (bus.Send) begin
        state <= bus.WriteRead ? WR_START : RD_WAIT;
        bus.Serial_ready <= 1'b0;
        bus.Data_pin_oe <= bus.WriteRead;
        bus.Data_pin_out <= bus.WriteRead ? START_BIT : 1'b1;
        bus.Read_FIFO <= bus.WriteRead;
        bit_cnt <= '0;
        word_cnt <= '0;
        to_cnt <= '0;
      end
      WR_START: begin
        state <= WR_DATA;
        bus.Data_pin_out <= tx_bit;
        sreg <= tx_next;
      end
      WR_DATA: begin
        bit_cnt <= bit_cnt + 5'd1;
        bus.Read_FIFO <= bit_cnt == 5'd30 && !last_word;
        if (bit_cnt == 5'd31 && !last_word) word_cnt <= word_cnt + 1'b1;
        if (data_last) begin
`ifdef SD_DATA_CRC16_EN
          state <= WR_CRC;
          bus.Data_pin_out <= crc[15];
          sreg <= {crc[14:0], 17'b0};
`else
          state <= WR_END;
          bus.Data_pin_out <= END_BIT;
`endif
        end else begin
          bus.Data_pin_out <= tx_bit;
          sreg <= tx_next;
        end
      end
      WR_CRC: begin
        bit_cnt <= bit_cnt + 5'd1;
        state <= bit_cnt == 5'(CRC_LEN - 1) ? WR_END : WR_CRC;
        bus.Data_pin_out <= bit_cnt == 5'(CRC_LEN - 1) ? END_BIT : sreg[31];
        sreg <= {sreg[30:0], 1'b0};
      end
      WR_END: begin
        state <= DONE;
        bus.Data_pin_out <= 1'b1;
        bus.Data_pin_oe <= 1'b0;
        bus.Complete <= 1'b1;
      end
      RD_WAIT: begin
        if (bus.Timeout_enable) to_cnt <= to_cnt + 1'b1;
        if (bus.Data_pin_in == START_BIT) begin
          state <= RD_DATA;
          bit_cnt <= '0;
        end else if (bus.Timeout_enable && to_cnt == bus.Timeout_reg) begin
          state <= DONE;
          bus.Timeout <= 1'b1;
        end
      end
      RD_DATA: begin
        bit_cnt <= bit_cnt + 5'd1;
        sreg <= {sreg[30:0], bus.Data_pin_in};
        if (bit_cnt == 5'd31) begin
          bus.Data_to_FIFO <= {sreg[30:0], bus.Data_pin_in};
          bus.Write_FIFO <= 1'b1;
          if (!last_word) word_cnt <= word_cnt + 1'b1;
        end
        if (data_last) begin
          bit_cnt <= '0;
`ifdef SD_DATA_CRC16_EN
          state <= RD_CRC;
`else
          state <= RD_END;
`endif
        end
      end
      RD_CRC: begin
        bit_cnt <= bit_cnt + 5'd1;
        sreg <= {sreg[30:0], bus.Data_pin_in};
        if (bit_cnt == 5'(CRC_LEN - 1)) state <= RD_END;
      end
      RD_END: begin
        state <= DONE;
        bus.Complete <= 1'b1;
`ifdef SD_DATA_CRC16_EN
        bus.CRC_error <= bus.Data_pin_in != END_BIT || sreg[15:0] != crc;
`else
        bus.CRC_error <= bus.Data_pin_in != END_BIT;
`endif
      end
      DONE: begin
        state <= IDLE;
        bus.Serial_ready <= 1'b1;
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_sd_data_phy.sv
// tb_sd_data_phy: scoreboard bench for sd_data_phy with BLOCK_WORDS=2
module tb_sd_data_phy;
  localparam int BW = 2;
`ifdef SD_DATA_CRC16_EN
  localparam int WR_LEN = 1 + 32 * BW + 16 + 1;
`else
  localparam int WR_LEN = 2 + 32 * BW;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sd_data_phy_if #(.TO_WIDTH(16)) bus ();
  sd_data_phy #(.BLOCK_WORDS(BW), .TO_WIDTH(16)) dut (.SD_clock(clk), .Reset(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int reads = 0;
  int completes = 0;
  logic exp_bits[$];
  logic [31:0] exp_words[$];
  logic [31:0] tx_words[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c;
    logic fb;
    c = '0;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  always @(posedge clk) if (bus.Read_FIFO && tx_words.size() > 0) void'(tx_words.pop_front());
  always @(negedge clk) begin
    bus.Data_from_FIFO = tx_words.size() > 0 ? tx_words[0] : 32'h0;
    if (!rst) begin
      if (bus.Data_pin_oe) begin
        chk("tx_avail", exp_bits.size() > 0, 1);
        if (exp_bits.size() > 0) chk("tx_bit", bus.Data_pin_out, exp_bits.pop_front());
      end
      if (bus.Write_FIFO) begin
        chk("rx_avail", exp_words.size() > 0, 1);
        if (exp_words.size() > 0) chk("rx_word", bus.Data_to_FIFO, exp_words.pop_front());
      end
      if (bus.Read_FIFO) reads++;
      if (bus.Complete) completes++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic wr);
    bus.Send = 1'b1;
    bus.WriteRead = wr;
    tick();
    bus.Send = 1'b0;
  endtask
  task automatic drive_bit(input logic b);
    bus.Data_pin_in = b;
    tick();
  endtask
  task automatic chk_reset_outs(input string tag);
    chk(tag, {bus.Serial_ready, bus.Data_pin_out, bus.Data_pin_oe, bus.Read_FIFO,
              bus.Write_FIFO, bus.Complete, bus.Timeout, bus.CRC_error}, 8'b1100_0000);
    chk({tag, "_data"}, bus.Data_to_FIFO, 32'h0);
  endtask
  task automatic do_write(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] d;
    int n;
    d = {w0, w1};
    tx_words.delete();
    tx_words.push_back(w0);
    tx_words.push_back(w1);
    exp_bits.push_back(1'b0);
    for (int i = 63; i >= 0; i--) exp_bits.push_back(d[i]);
`ifdef SD_DATA_CRC16_EN
    for (int i = 15; i >= 0; i--) exp_bits.push_back(crc16(d)[i]);
`endif
    exp_bits.push_back(1'b1);
    reads = 0;
    completes = 0;
    send(1'b1);
    n = 0;
    while (!bus.Complete && n < 200) begin
      tick();
      n++;
    end
    chk("wr_latency", n, WR_LEN);
    chk("wr_crc_err", bus.CRC_error, 0);
    chk("wr_reads", reads, BW);
    chk("wr_bits_left", exp_bits.size(), 0);
    tick();
    chk("wr_after", {bus.Serial_ready, bus.Complete, bus.Data_pin_oe, bus.Data_pin_out}, 4'b1001);
    chk("wr_complete_once", completes, 1);
  endtask
  task automatic do_read(input logic [31:0] w0, input logic [31:0] w1, input int flip,
                         input logic endb, input logic exp_err);
    logic [63:0] d;
    logic [15:0] c;
    int n;
    d = {w0, w1};
    c = crc16(d);
    if (flip >= 0) c[flip] = ~c[flip];
    exp_words.push_back(w0);
    exp_words.push_back(w1);
    completes = 0;
    send(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    for (int i = 63; i >= 0; i--) drive_bit(d[i]);
`ifdef SD_DATA_CRC16_EN
    for (int i = 15; i >= 0; i--) drive_bit(c[i]);
`endif
    drive_bit(endb);
    bus.Data_pin_in = 1'b1;
    n = 0;
    while (!bus.Complete && n < 8) begin
      tick();
      n++;
    end
    chk("rd_done_latency", n, 0);
    chk("rd_crc_err", bus.CRC_error, exp_err);
    chk("rd_words_left", exp_words.size(), 0);
    tick();
    chk("rd_after", {bus.Serial_ready, bus.Complete, bus.CRC_error}, 3'b100);
    chk("rd_complete_once", completes, 1);
  endtask
  task automatic do_timeout(input logic [15:0] lim);
    int n;
    completes = 0;
    bus.Timeout_enable = 1'b1;
    bus.Timeout_reg = lim;
    bus.Data_pin_in = 1'b1;
    send(1'b0);
    n = 0;
    while (!bus.Timeout && n < 300) begin
      tick();
      n++;
    end
    chk("to_latency", n, lim + 1);
    chk("to_ready_low", bus.Serial_ready, 0);
    tick();
    chk("to_after", {bus.Serial_ready, bus.Timeout, bus.Complete}, 3'b100);
    chk("to_no_complete", completes, 0);
    bus.Timeout_enable = 1'b0;
  endtask
  initial begin
    bus.Send = 1'b0;
    bus.Idle = 1'b0;
    bus.WriteRead = 1'b0;
    bus.Timeout_enable = 1'b0;
    bus.Timeout_reg = '0;
    bus.Data_pin_in = 1'b1;
    repeat (3) tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();
    do_write(32'hA5A50F0F, 32'h12345678);
    do_read(32'hDEADBEEF, 32'h00000001, -1, 1'b1, 1'b0);
`ifdef SD_DATA_CRC16_EN
    do_read(32'hCAFEF00D, 32'h0F0F0F0F, 5, 1'b1, 1'b1);
`endif
    do_read(32'h13572468, 32'hFFFFFFFF, -1, 1'b0, 1'b1);
    do_timeout(16'd70);
    do_timeout(16'd0);
    send(1'b0);
    repeat (100) tick();
    chk("noto_waiting", bus.Serial_ready, 0);
    bus.Idle = 1'b1;
    tick();
    bus.Idle = 1'b0;
    chk("noto_abort", {bus.Serial_ready, bus.Timeout, bus.Complete}, 3'b100);
    tx_words.push_back(32'hF0E1D2C3);
    tx_words.push_back(32'h01234567);
    exp_bits.push_back(1'b0);
    for (int i = 31; i >= 21; i--) exp_bits.push_back(tx_words[0][i]);
    completes = 0;
    send(1'b1);
    repeat (11) tick();
    bus.Idle = 1'b1;
    bus.Send = 1'b1;
    tick();
    bus.Idle = 1'b0;
    bus.Send = 1'b0;
    chk("idle_abort", {bus.Serial_ready, bus.Data_pin_out, bus.Data_pin_oe}, 3'b110);
    chk("idle_bits_left", exp_bits.size(), 0);
    tick();
    chk("idle_no_complete", completes, 0);
    tx_words.delete();
    do_write(32'h0BADC0DE, 32'h80000001);
    exp_words.push_back(32'h89ABCDEF);
    send(1'b0);
    drive_bit(1'b0);
    for (int i = 31; i >= 0; i--) drive_bit(exp_words[0][i]);
    repeat (5) drive_bit(1'b1);
    chk("rst_mid_words_left", exp_words.size(), 0);
    rst = 1'b1;
    tick();
    chk_reset_outs("rst_mid");
    rst = 1'b0;
    tick();
    do_write(32'h55AA33CC, 32'hFFFF0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
